// File: rtl/led_pwm_blinker_if.sv
// Avalon-MM register bus for led_pwm_blinker.
// Ports: address/chipselect/write_n/writedata from master; readdata from slave.
interface led_pwm_blinker_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/led_pwm_blinker.sv
// LED stage after the PIO: global PWM brightness plus per-LED blink mask.
// Ports: clk, reset_n (async low), bus (Avalon-MM slave), pattern_in, led_out.
// Optional LED_FADE_EN: duty_eff ramps one step per PWM period toward duty_tgt.
module led_pwm_blinker #(
    parameter int LED_W        = 8,
    parameter int PWM_PRESCALE = 4,
    parameter int BLINK_W      = 16,
    parameter int DUTY_RESET   = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    led_pwm_blinker_if.slave   bus,
    input  logic [LED_W-1:0]   pattern_in,
    output logic [LED_W-1:0]   led_out
);

    localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [PW-1:0]      presc_q, presc_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [7:0]         duty_tgt_q, duty_tgt_d;
    logic [7:0]         duty_eff;
    logic [BLINK_W-1:0] half_per_q, half_per_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic [LED_W-1:0]   mask_q, mask_d;
    logic [LED_W-1:0]   led_out_q, led_out_d;

    logic wr;
    logic pwm_tick;
    logic wrap;
    logic pwm_on;
    logic unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign pwm_tick  = (presc_q == PW'(PWM_PRESCALE - 1));
    assign wrap      = pwm_tick & (pwm_cnt_q == 8'hFF);
    assign pwm_on    = (duty_eff == 8'hFF) | (pwm_cnt_q < duty_eff);
    assign led_out   = led_out_q;
    assign unused_wd = ^bus.writedata;

`ifdef LED_FADE_EN
    logic [7:0] duty_eff_q, duty_eff_d;

    assign duty_eff = duty_eff_q;

    always_comb begin
        duty_eff_d = duty_eff_q;
        if (wrap) begin
            if (duty_eff_q < duty_tgt_q)
                duty_eff_d = duty_eff_q + 8'd1;
            else if (duty_eff_q > duty_tgt_q)
                duty_eff_d = duty_eff_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) duty_eff_q <= 8'(DUTY_RESET);
        else          duty_eff_q <= duty_eff_d;
    end
`else
    assign duty_eff = duty_tgt_q;
`endif

    always_comb begin
        presc_d     = presc_q;
        pwm_cnt_d   = pwm_cnt_q;
        duty_tgt_d  = duty_tgt_q;
        half_per_d  = half_per_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        mask_d      = mask_q;

        if (pwm_tick) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end else begin
            presc_d   = presc_q + PW'(1);
        end

        if (half_per_q == '0) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
        end else if (wrap) begin
            if (blink_cnt_q == half_per_q - BLINK_W'(1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end

        // A half-period write restarts the blink phase even on a wrap.
        if (wr) begin
            unique case (bus.address)
                2'd0: duty_tgt_d = bus.writedata[7:0];
                2'd1: begin
                    half_per_d  = bus.writedata[BLINK_W-1:0];
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b1;
                end
                2'd2: mask_d = bus.writedata[LED_W-1:0];
                2'd3: ;
            endcase
        end

        led_out_d = pattern_in
                  & {LED_W{pwm_on}}
                  & (~mask_q | {LED_W{blink_ph_q}});
    end

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            2'd0: bus.readdata = {24'b0, duty_tgt_q};
            2'd1: bus.readdata = 32'(half_per_q);
            2'd2: bus.readdata = 32'(mask_q);
            2'd3: bus.readdata = {15'b0, blink_ph_q, duty_eff, pwm_cnt_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            duty_tgt_q  <= 8'(DUTY_RESET);
            half_per_q  <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
            mask_q      <= '0;
            led_out_q   <= '0;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_tgt_q  <= duty_tgt_d;
            half_per_q  <= half_per_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            mask_q      <= mask_d;
            led_out_q   <= led_out_d;
        end
    end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Directed self-checking bench for led_pwm_blinker.
// Drives and samples 1 ns after each rising edge.
module tb_led_pwm_blinker;

    logic       clk;
    logic       reset_n;
    logic [7:0] pattern_in;
    logic [7:0] led_out;

    int n_chk  = 0;
    int n_pass = 0;

    led_pwm_blinker_if bus();

    led_pwm_blinker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    // Leaves the bench one cycle before the edge where pwm_cnt wraps.
    task automatic sync_pre_wrap();
        int n;
        logic [31:0] s;
        n = 0;
        rd(2'd3, s);
        while (s[7:0] != 8'd254 && n < 3000) begin
            tick(); rd(2'd3, s); n++;
        end
        while (s[7:0] != 8'd255 && n < 3000) begin
            tick(); rd(2'd3, s); n++;
        end
        if (n >= 3000) chk("sync_timeout", 32'(n), 32'd0);
        repeat (3) tick();
    endtask

    task automatic count_eq(input logic [7:0] v, output int cnt);
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            if (led_out == v) cnt++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] r;
        int c;

        reset_n        = 1'b0;
        pattern_in     = 8'hA5;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) tick();

        chk("rst_led", 32'(led_out), 32'h0);
        rd(2'd3, r);
        chk("rst_status", r, 32'h0001_FF00);

        reset_n = 1'b1;
        tick();
        chk("t1_led", 32'(led_out), 32'hA5);

`ifdef LED_FADE_EN
        wr(2'd0, 32'd250);
        for (int k = 254; k >= 250; k--) begin
            sync_pre_wrap();
            tick();
            rd(2'd3, r);
            chk("fade_step", 32'(r[15:8]), 32'(k));
        end
        sync_pre_wrap();
        tick();
        rd(2'd3, r);
        chk("fade_hold", 32'(r[15:8]), 32'd250);
`else
        pattern_in = 8'h5A;
        #1;
        chk("pat_hold", 32'(led_out), 32'hA5);
        tick();
        chk("pat_lat", 32'(led_out), 32'h5A);

        pattern_in = 8'hFF;
        wr(2'd0, 32'd64);
        rd(2'd3, r);
        chk("duty_eff", 32'(r[15:8]), 32'd64);
        rd(2'd0, r);
        chk("duty_rd", r, 32'd64);
        tick();
        count_eq(8'hFF, c);
        chk("d64_on", 32'(c), 32'd256);
        count_eq(8'h00, c);
        chk("d64_off", 32'(c), 32'd768);

        wr(2'd0, 32'd0);
        tick();
        count_eq(8'h00, c);
        chk("d0_off", 32'(c), 32'd1024);

        pattern_in = 8'h3C;
        wr(2'd0, 32'd255);
        tick();
        count_eq(8'h3C, c);
        chk("d255_on", 32'(c), 32'd1024);

        wr(2'd3, 32'h0000_1234);
        rd(2'd3, r);
        chk("ro_status", 32'(r[15:8]), 32'hFF);

        pattern_in = 8'hFF;
        wr(2'd2, 32'h0F);
        rd(2'd2, r);
        chk("mask_rd", r, 32'h0F);

        // half_per=2 written on a wrap; low nibble toggles every 2 periods
        sync_pre_wrap();
        wr(2'd1, 32'd2);
        sync_pre_wrap();
        tick();
        chk("bl_w1", 32'(led_out), 32'hFF);
        sync_pre_wrap();
        tick();
        chk("bl_w2_lat", 32'(led_out), 32'hFF);
        tick();
        chk("bl_w2_off", 32'(led_out), 32'hF0);
        sync_pre_wrap();
        tick(); tick();
        chk("bl_w3", 32'(led_out), 32'hF0);
        sync_pre_wrap();
        tick(); tick();
        chk("bl_w4_on", 32'(led_out), 32'hFF);

        // half_per=1 toggles every wrap; find a wrap with phase 1
        wr(2'd1, 32'd1);
        sync_pre_wrap();
        rd(2'd3, r);
        if (r[16] == 1'b0) sync_pre_wrap();
        rd(2'd3, r);
        chk("t5_pre_ph", 32'(r[16]), 32'd1);
        wr(2'd1, 32'd3);
        rd(2'd3, r);
        chk("t5_wrap", 32'(r[7:0]), 32'd0);
        chk("t5_ph", 32'(r[16]), 32'd1);
        rd(2'd1, r);
        chk("hp_rd", r, 32'd3);
        sync_pre_wrap();
        tick();
        sync_pre_wrap();
        tick();
        rd(2'd3, r);
        chk("t5_cnt2", 32'(r[16]), 32'd1);
        sync_pre_wrap();
        tick();
        rd(2'd3, r);
        chk("t5_cnt3", 32'(r[16]), 32'd0);

        // async reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_led", 32'(led_out), 32'h0);
        rd(2'd3, r);
        chk("mid_rst_st", r, 32'h0001_FF00);
        rd(2'd1, r);
        chk("mid_rst_hp", r, 32'h0);
        rd(2'd2, r);
        chk("mid_rst_mask", r, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
